// File: rtl/hs_4_phase_rx_if.sv
// Bundle for the 4-phase peer handshake and the downstream valid/ready port.
// The master side is the environment (peer plus downstream sink) and the
// slave side is the receiver block.
interface hs_4_phase_rx_if #(
  parameter int unsigned G_WIDTH     = 4,
  parameter int unsigned G_CNT_WIDTH = 8
);
  logic                   i_req;
  logic [G_WIDTH-1:0]     i_data;
  logic                   o_ack;
  logic                   o_valid;
  logic                   i_ready;
  logic [G_WIDTH-1:0]     o_data;
  logic                   o_busy;
  logic                   o_err;
  logic [G_CNT_WIDTH-1:0] o_count;

  modport master (
    output i_req, i_data, i_ready,
    input  o_ack, o_valid, o_data, o_busy, o_err, o_count
  );

  modport slave (
    input  i_req, i_data, i_ready,
    output o_ack, o_valid, o_data, o_busy, o_err, o_count
  );
endinterface

// File: rtl/hs_4_phase_rx.sv
// 4-phase handshake receiver: synchronizes an asynchronous request, captures
// the peer word, offers it downstream with valid/ready and only acknowledges
// the peer once downstream has accepted it.
module hs_4_phase_rx #(
  parameter int unsigned G_STAGES    = 2,
  parameter int unsigned G_WIDTH     = 4,
  parameter int unsigned G_CNT_WIDTH = 8
) (
  input logic           i_clk,
  input logic           i_rst,
  hs_4_phase_rx_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StAck  = 2'd2
  } state_e;

  state_e                 state_q;
  logic [G_STAGES-1:0]    sync_q;
  logic                   req_sync;
  logic                   ack_q;
  logic                   valid_q;
  logic                   busy_q;
  logic                   err_q;
  logic [G_WIDTH-1:0]     data_q;
  logic [G_CNT_WIDTH-1:0] count_q;

  assign req_sync = sync_q[G_STAGES-1];

  // Request synchronizer; bit 0 is the only flop that sees the raw request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[G_STAGES-2:0], bus.i_req};
    end
  end

  // Handshake FSM with all outputs registered; busy tracks the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          ack_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          if (req_sync) begin
            data_q  <= bus.i_data;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StHold;
          end
        end
        StHold: begin
          busy_q <= 1'b1;
          // Peer dropped its request before we acked: flag it, but still finish.
          if (!req_sync) begin
            err_q <= 1'b1;
          end
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= StAck;
          end
        end
        StAck: begin
          busy_q <= 1'b1;
          if (!req_sync) begin
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= count_q + 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.o_ack   = ack_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_err   = err_q;
  assign bus.o_data  = data_q;
  assign bus.o_count = count_q;

endmodule

// File: tb/tb_hs_4_phase_rx.sv
// Self-checking bench for hs_4_phase_rx: a transaction-level model of the
// receiver is compared against the DUT every cycle, plus literal checks of
// the directed scenarios.
module tb_hs_4_phase_rx;

  localparam int unsigned STAGES = 2;
  localparam int unsigned W      = 4;
  localparam int unsigned CW     = 8;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  bit   chk_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  hs_4_phase_rx_if #(.G_WIDTH(W), .G_CNT_WIDTH(CW)) bus ();

  hs_4_phase_rx #(
    .G_STAGES   (STAGES),
    .G_WIDTH    (W),
    .G_CNT_WIDTH(CW)
  ) u_dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  always #5 i_clk = ~i_clk;

  // Model: the request is seen STAGES edges late; a word is either pending
  // downstream, waiting for the peer to drop its request, or absent.
  logic [STAGES-1:0] m_hist  = '0;
  logic              m_pend  = 1'b0;
  logic              m_acked = 1'b0;
  logic              m_err   = 1'b0;
  logic [W-1:0]      m_data  = '0;
  logic [CW-1:0]     m_count = '0;

  always @(posedge i_clk) begin
    logic          seen;
    logic          pend;
    logic          acked;
    logic          err;
    logic [W-1:0]  data;
    logic [CW-1:0] cnt;
    seen  = m_hist[STAGES-1];
    pend  = m_pend;
    acked = m_acked;
    err   = m_err;
    data  = m_data;
    cnt   = m_count;
    if (i_rst) begin
      pend = 0; acked = 0; err = 0; data = '0; cnt = '0;
    end else if (pend) begin
      if (!seen) err = 1;
      if (bus.i_ready) begin pend = 0; acked = 1; end
    end else if (acked) begin
      if (!seen) begin acked = 0; cnt = cnt + 1; end
    end else if (seen) begin
      pend = 1; data = bus.i_data;
    end
    m_hist  <= i_rst ? '0 : {m_hist[STAGES-2:0], bus.i_req};
    m_pend  <= pend;
    m_acked <= acked;
    m_err   <= err;
    m_data  <= data;
    m_count <= cnt;
  end

  // Words accepted downstream, in order.
  logic [W-1:0] rx_q[$];
  always @(posedge i_clk) begin
    if (!i_rst && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) rx_q.push_back(bus.o_data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge i_clk) begin
    if (chk_en) begin
      check("model_ack",   32'(bus.o_ack),   32'(m_acked));
      check("model_valid", 32'(bus.o_valid), 32'(m_pend));
      check("model_busy",  32'(bus.o_busy),  32'(m_pend | m_acked));
      check("model_err",   32'(bus.o_err),   32'(m_err));
      check("model_count", 32'(bus.o_count), 32'(m_count));
      if (m_pend) check("model_data", 32'(bus.o_data), 32'(m_data));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wait_ack(input logic v, input int budget);
    int n = 0;
    while (bus.o_ack !== v && n < budget) begin @(negedge i_clk); n++; end
    check("wait_ack", 32'(bus.o_ack), 32'(v));
  endtask

  task automatic wait_valid(input logic v, input int budget);
    int n = 0;
    while (bus.o_valid !== v && n < budget) begin @(negedge i_clk); n++; end
    check("wait_valid", 32'(bus.o_valid), 32'(v));
  endtask

  // One complete 4-phase handshake from the peer side.
  task automatic xfer(input logic [W-1:0] d, input bit rand_ready);
    int n = 0;
    bus.i_data = d;
    bus.i_req  = 1'b1;
    while (bus.o_ack !== 1'b1 && n < 200) begin
      bus.i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge i_clk);
      n++;
    end
    check("xfer_ack_hi", 32'(bus.o_ack), 32'd1);
    bus.i_req = 1'b0;
    wait_ack(1'b0, 20);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step(2);
    i_rst = 1'b0;
  endtask

  initial begin
    bus.i_req   = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    step(2);
    chk_en = 1'b1;
    check("rst_ack",   32'(bus.o_ack),   32'd0);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_busy",  32'(bus.o_busy),  32'd0);
    check("rst_err",   32'(bus.o_err),   32'd0);
    check("rst_data",  32'(bus.o_data),  32'd0);
    check("rst_count", 32'(bus.o_count), 32'd0);
    i_rst = 1'b0;

    // Basic transfer with the edge-accurate timing.
    bus.i_data = 4'hA; bus.i_ready = 1'b1; bus.i_req = 1'b1;
    step(2);
    check("basic_valid_e2", 32'(bus.o_valid), 32'd0);
    step(1);
    check("basic_valid_e3", 32'(bus.o_valid), 32'd1);
    check("basic_data_e3",  32'(bus.o_data),  32'hA);
    check("basic_busy_e3",  32'(bus.o_busy),  32'd1);
    step(1);
    check("basic_ack_e4",   32'(bus.o_ack),   32'd1);
    check("basic_valid_e4", 32'(bus.o_valid), 32'd0);
    bus.i_req = 1'b0;
    step(2);
    check("basic_ack_hold", 32'(bus.o_ack), 32'd1);
    step(1);
    check("basic_ack_drop", 32'(bus.o_ack),   32'd0);
    check("basic_count",    32'(bus.o_count), 32'd1);
    check("basic_busy_end", 32'(bus.o_busy),  32'd0);

    // Backpressure: word held, no ack, until ready.
    bus.i_ready = 1'b0; bus.i_data = 4'h5; bus.i_req = 1'b1;
    wait_valid(1'b1, 10);
    step(10);
    check("bp_valid", 32'(bus.o_valid), 32'd1);
    check("bp_data",  32'(bus.o_data),  32'h5);
    check("bp_ack",   32'(bus.o_ack),   32'd0);
    bus.i_ready = 1'b1;
    step(1);
    check("bp_ack_rise", 32'(bus.o_ack), 32'd1);
    bus.i_req = 1'b0;
    wait_ack(1'b0, 10);
    check("bp_count", 32'(bus.o_count), 32'd2);

    // Early withdrawal: sticky error, word still delivered.
    bus.i_ready = 1'b0; bus.i_data = 4'h3; bus.i_req = 1'b1;
    wait_valid(1'b1, 10);
    bus.i_req = 1'b0;
    step(4);
    check("ew_err",   32'(bus.o_err),   32'd1);
    check("ew_valid", 32'(bus.o_valid), 32'd1);
    check("ew_data",  32'(bus.o_data),  32'h3);
    bus.i_ready = 1'b1;
    step(1);
    check("ew_ack_one", 32'(bus.o_ack), 32'd1);
    step(1);
    check("ew_ack_drop", 32'(bus.o_ack),   32'd0);
    check("ew_count",    32'(bus.o_count), 32'd3);
    step(5);
    check("ew_err_sticky", 32'(bus.o_err), 32'd1);
    i_rst = 1'b1;
    step(1);
    check("ew_err_clr", 32'(bus.o_err),   32'd0);
    check("ew_cnt_clr", 32'(bus.o_count), 32'd0);
    i_rst = 1'b0;

    // Reset while ack is high, request held through release.
    bus.i_ready = 1'b1; bus.i_data = 4'h9; bus.i_req = 1'b1;
    wait_ack(1'b1, 10);
    i_rst = 1'b1;
    step(1);
    check("rack_ack",   32'(bus.o_ack),   32'd0);
    check("rack_valid", 32'(bus.o_valid), 32'd0);
    check("rack_busy",  32'(bus.o_busy),  32'd0);
    check("rack_count", 32'(bus.o_count), 32'd0);
    i_rst = 1'b0;
    step(2);
    check("rack_valid_e2", 32'(bus.o_valid), 32'd0);
    step(1);
    check("rack_valid_e3", 32'(bus.o_valid), 32'd1);
    check("rack_data_e3",  32'(bus.o_data),  32'h9);
    bus.i_req = 1'b0;
    wait_ack(1'b1, 5);
    wait_ack(1'b0, 10);
    check("rack_count_end", 32'(bus.o_count), 32'd1);
    check("rack_err_end",   32'(bus.o_err),   32'd0);

    // Random peer and sink behaviour, including early withdrawals.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bus.i_req = ~bus.i_req;
      bus.i_ready = 1'($urandom_range(0, 1));
      bus.i_data  = W'($urandom);
      step(1);
    end
    bus.i_req = 1'b0; bus.i_ready = 1'b1;
    step(20);
    check("rand_idle", 32'(bus.o_busy), 32'd0);

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 256; i++) xfer(W'($urandom), 1'b1);
    check("wrap_256", 32'(bus.o_count), 32'h00);
    xfer(W'($urandom), 1'b1);
    check("wrap_257", 32'(bus.o_count), 32'h01);

    // Back-to-back words, peer re-raises as soon as ack falls.
    do_reset();
    rx_q.delete();
    bus.i_ready = 1'b1;
    for (int w = 1; w <= 4; w++) xfer(W'(w), 1'b0);
    check("b2b_n", 32'(rx_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) check("b2b_word", 32'(rx_q[i]), 32'(i + 1));
    check("b2b_count", 32'(bus.o_count), 32'd4);
    check("b2b_err",   32'(bus.o_err),   32'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
